axi_lite_master: RTL
====================

AXI_LITE_MASTER -- requirements
Module: axi_lite_master

Interface
REQ-001 Parameter ADDR_WIDTH, default 9: AXI-Lite address width.
REQ-002 Parameter DATA_WIDTH, default 32: data width, fixed at 32; wstrb width is DATA_WIDTH/8.
REQ-003 m_axi_aclk  in  1  single clock; all logic on its rising edge.
REQ-004 m_axi_areset  in  1  asynchronous, active-high reset.
REQ-005 cmd_valid in 1, cmd_ready out 1: command handshake, accepted when both are high on a clock edge.
REQ-006 cmd_write  in  1  1 = write, 0 = read.
REQ-007 cmd_addr  in  ADDR_WIDTH  byte address.
REQ-008 cmd_wdata  in  DATA_WIDTH  write data; ignored for reads.
REQ-009 cmd_wstrb  in  DATA_WIDTH/8  byte strobes; ignored for reads.
REQ-010 rsp_valid out 1, rsp_ready in 1: response handshake.
REQ-011 rsp_write  out  1  echoes cmd_write of the completed transaction.
REQ-012 rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
REQ-013 rsp_resp  out  2  BRESP or RRESP of the completed transaction.
REQ-014 AW channel: m_axi_awaddr out ADDR_WIDTH, m_axi_awvalid out 1, m_axi_awready in 1.
REQ-015 W channel: m_axi_wdata out DATA_WIDTH, m_axi_wstrb out DATA_WIDTH/8, m_axi_wvalid out 1, m_axi_wready in 1.
REQ-016 B channel: m_axi_bresp in 2, m_axi_bvalid in 1, m_axi_bready out 1.
REQ-017 AR channel: m_axi_araddr out ADDR_WIDTH, m_axi_arvalid out 1, m_axi_arready in 1.
REQ-018 R channel: m_axi_rdata in DATA_WIDTH, m_axi_rresp in 2, m_axi_rvalid in 1, m_axi_rready out 1.

Function
REQ-019 FSM states are IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA and RSP; exactly one transaction is outstanding at a time.
REQ-020 cmd_ready is high only in IDLE.
REQ-021 On command acceptance, the address, data, strobe and direction are registered; the FSM goes to WR_REQ (write) or RD_REQ (read) on the next cycle.
REQ-022 WR_REQ: awvalid and wvalid assert together, in the cycle after acceptance.
REQ-023 WR_REQ: each valid drops independently the cycle after its own ready is sampled high.
REQ-024 WR_REQ: AW and W may complete in either order or in the same cycle; the FSM leaves for WR_RESP once both have completed.
REQ-025 WR_RESP: bready is high; on bvalid, bresp is captured, rsp_rdata is set to 0, and the FSM goes to RSP.
REQ-026 RD_REQ: arvalid is high until arready is sampled high, then the FSM goes to RD_DATA.
REQ-027 RD_DATA: rready is high; on rvalid, rdata and rresp are captured and the FSM goes to RSP.
REQ-028 RSP: rsp_valid is high with stable payload until rsp_ready; then the FSM returns to IDLE.
REQ-029 Minimum command-to-IDLE latency is 4 cycles, with all AXI readies high and rsp_ready high.
REQ-030 A valid, once asserted, never deasserts before its handshake, and its payload is held constant.
REQ-031 Valids never depend combinationally on readies.
REQ-032 bready and rready are high only in WR_RESP and RD_DATA respectively.
REQ-033 bvalid or rvalid arriving outside the matching state is ignored.
REQ-034 No cmd_valid is accepted while rsp_valid is high, so there is back-pressure and no response loss.
REQ-035 SLVERR (2'b10) and DECERR (2'b11) responses are passed through unchanged; they do not trigger a retry.

Reset
REQ-036 Asynchronous assertion forces IDLE and drives to 0: all valid outputs, bready, rready, cmd_ready, rsp_write, rsp_rdata, rsp_resp, and all AXI address, data and strobe outputs.
REQ-037 Reset mid-transaction abandons the transaction; no response is produced.
REQ-038 After deassertion, cmd_ready is 1 from the first clock edge.

Verification
REQ-039 Write, addr 0x004, data 0xA5A5_5A5A, strb 0xF, all readies high -> one AW and one W beat with those values; rsp_write=1, rsp_resp=0, rsp_rdata=0.
REQ-040 Write with wready delayed 3 cycles after awready -> awvalid drops after 1 cycle; wvalid is held 4 cycles with stable data; exactly one B accepted.
REQ-041 Read, addr 0x008, slave returns 0x0000_00FF with rresp=0 after 5 cycles of rvalid low -> rready is held throughout; rsp_rdata=0x0000_00FF, rsp_write=0.
REQ-042 Read with rresp=2'b10 and rsp_ready held low 10 cycles -> rsp_valid is held with stable payload; cmd_ready stays 0 until the response handshake.
REQ-043 Reset asserted while in WR_RESP -> all outputs are 0 asynchronously; after release no rsp_valid appears and the next command completes normally.
REQ-044 Back-to-back reads to 0x000 and then 0x100 with cmd_valid held high -> second arvalid does not assert before the first response handshake; addresses are issued in order.

Source files
------------

// File: rtl/axi_lite_master.sv
// axi_lite_master
// Turns a simple command/response handshake into single AXI4-Lite read or
// write transactions. Exactly one transaction is in flight at a time; the
// command port is only ready in IDLE, so a pending response naturally
// back-pressures new commands. Every output is driven straight from a flop.

module axi_lite_master #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    m_axi_aclk,
  input  logic                    m_axi_areset,

  // Command port
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,

  // Response port
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,

  // AW channel
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,

  // W channel
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,

  // B channel
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,

  // AR channel
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,

  // R channel
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4,
    RSP     = 3'd5
  } state_e;

  state_e                  state_r;

  // Registered command / handshake state
  logic                    write_r;
  logic                    cmd_ready_r;
  logic                    awvalid_r;
  logic                    wvalid_r;
  logic                    bready_r;
  logic                    arvalid_r;
  logic                    rready_r;
  logic                    rsp_valid_r;
  logic                    rsp_write_r;
  logic [DATA_WIDTH-1:0]   rsp_rdata_r;
  logic [1:0]              rsp_resp_r;
  logic [ADDR_WIDTH-1:0]   awaddr_r;
  logic [DATA_WIDTH-1:0]   wdata_r;
  logic [STRB_WIDTH-1:0]   wstrb_r;
  logic [ADDR_WIDTH-1:0]   araddr_r;

  // A write channel counts as finished once its valid has already dropped,
  // or if its handshake completes on the current edge. Waiting for both lets
  // AW and W finish in either order or together.
  logic                    aw_done_s;
  logic                    w_done_s;

  assign aw_done_s = (~awvalid_r) | m_axi_awready;
  assign w_done_s  = (~wvalid_r)  | m_axi_wready;

  // Transaction FSM; all outputs are registered here so valids never
  // depend combinationally on readies.
  always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
    if (m_axi_areset) begin
      state_r     <= IDLE;
      write_r     <= 1'b0;
      cmd_ready_r <= 1'b0;
      awvalid_r   <= 1'b0;
      wvalid_r    <= 1'b0;
      bready_r    <= 1'b0;
      arvalid_r   <= 1'b0;
      rready_r    <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_write_r <= 1'b0;
      rsp_rdata_r <= {DATA_WIDTH{1'b0}};
      rsp_resp_r  <= 2'b00;
      awaddr_r    <= {ADDR_WIDTH{1'b0}};
      wdata_r     <= {DATA_WIDTH{1'b0}};
      wstrb_r     <= {STRB_WIDTH{1'b0}};
      araddr_r    <= {ADDR_WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (cmd_ready_r && cmd_valid) begin
            // Capture the command; the AXI request goes out next cycle.
            cmd_ready_r <= 1'b0;
            write_r     <= cmd_write;
            if (cmd_write) begin
              awaddr_r  <= cmd_addr;
              wdata_r   <= cmd_wdata;
              wstrb_r   <= cmd_wstrb;
              awvalid_r <= 1'b1;
              wvalid_r  <= 1'b1;
              state_r   <= WR_REQ;
            end else begin
              araddr_r  <= cmd_addr;
              arvalid_r <= 1'b1;
              state_r   <= RD_REQ;
            end
          end else begin
            // Comes out of reset with cmd_ready low; raise it on the first edge.
            cmd_ready_r <= 1'b1;
          end
        end

        WR_REQ: begin
          if (awvalid_r && m_axi_awready) begin
            awvalid_r <= 1'b0;
          end
          if (wvalid_r && m_axi_wready) begin
            wvalid_r <= 1'b0;
          end
          if (aw_done_s && w_done_s) begin
            bready_r <= 1'b1;
            state_r  <= WR_RESP;
          end
        end

        WR_RESP: begin
          if (m_axi_bvalid) begin
            bready_r    <= 1'b0;
            rsp_valid_r <= 1'b1;
            rsp_write_r <= write_r;
            rsp_rdata_r <= {DATA_WIDTH{1'b0}};
            rsp_resp_r  <= m_axi_bresp;
            state_r     <= RSP;
          end
        end

        RD_REQ: begin
          if (m_axi_arready) begin
            arvalid_r <= 1'b0;
            rready_r  <= 1'b1;
            state_r   <= RD_DATA;
          end
        end

        RD_DATA: begin
          if (m_axi_rvalid) begin
            rready_r    <= 1'b0;
            rsp_valid_r <= 1'b1;
            rsp_write_r <= write_r;
            rsp_rdata_r <= m_axi_rdata;
            rsp_resp_r  <= m_axi_rresp;
            state_r     <= RSP;
          end
        end

        RSP: begin
          // Payload holds until the consumer takes it; error codes pass as-is.
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            cmd_ready_r <= 1'b1;
            state_r     <= IDLE;
          end
        end

        default: begin
          // Unreachable encodings: drop every handshake and resynchronise.
          state_r     <= IDLE;
          cmd_ready_r <= 1'b0;
          awvalid_r   <= 1'b0;
          wvalid_r    <= 1'b0;
          bready_r    <= 1'b0;
          arvalid_r   <= 1'b0;
          rready_r    <= 1'b0;
          rsp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready     = cmd_ready_r;
  assign rsp_valid     = rsp_valid_r;
  assign rsp_write     = rsp_write_r;
  assign rsp_rdata     = rsp_rdata_r;
  assign rsp_resp      = rsp_resp_r;
  assign m_axi_awaddr  = awaddr_r;
  assign m_axi_awvalid = awvalid_r;
  assign m_axi_wdata   = wdata_r;
  assign m_axi_wstrb   = wstrb_r;
  assign m_axi_wvalid  = wvalid_r;
  assign m_axi_bready  = bready_r;
  assign m_axi_araddr  = araddr_r;
  assign m_axi_arvalid = arvalid_r;
  assign m_axi_rready  = rready_r;

endmodule
